// File: rtl/regfile_pkg.sv
// Shared register-file types: address/data widths and the write-back entry
// carried by the multi-cycle result queue.
package regfile_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wr;
        logic [REG_DW-1:0] d;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order ring buffer of pending write-back entries with squash-by-address,
// used to hold multi-cycle results until the register-file write port is free.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         push,
    input  wb_entry_t                    push_entry,
    input  logic                         pop,
    input  logic                         squash,
    input  logic [REG_AW-1:0]            squash_wr,
    output wb_entry_t                    head,
    output wb_entry_t [DEPTH-1:0]        ents,
    output logic [$clog2(DEPTH+1)-1:0]   cnt,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;
    logic                  push_hit;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign push_hit = squash && (push_entry.wr == squash_wr);
    assign head     = mem[rd_ptr];
    assign ents     = mem;

    // Valid bits double as occupancy: cleared on pop, squash and clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (squash && (mem[i].wr == squash_wr)) begin
                    mem[i].valid <= 1'b0;
                end
            end
            if (do_pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + PW'(1);
            end
            if (do_push) begin
                mem[wr_ptr].valid <= push_entry.valid && !push_hit;
                mem[wr_ptr].wr    <= push_entry.wr;
                mem[wr_ptr].d     <= push_entry.d;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port master: ALU results win the port, multi-cycle results
// queue in wb_fifo and drain in order. Optional forwarding ports under WB_BYPASS_EN.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = REG_DW,
    parameter int unsigned AW    = REG_AW
) (
    input  logic                       Clk,
    input  logic                       Clr,
    input  logic                       A_Valid,
    input  logic [AW-1:0]              A_Wr,
    input  logic [DW-1:0]              A_D,
    input  logic                       M_Valid,
    output logic                       M_Ready,
    input  logic [AW-1:0]              M_Wr,
    input  logic [DW-1:0]              M_D,
    output logic [AW-1:0]              Wr,
    output logic [DW-1:0]              D,
    output logic                       We,
    output logic [(1<<AW)-1:0]         Pend,
    output logic [$clog2(DEPTH+1)-1:0] Cnt
`ifdef WB_BYPASS_EN
    ,
    input  logic [AW-1:0]              Ra,
    input  logic [AW-1:0]              Rb,
    output logic [DW-1:0]              Qa_fwd,
    output logic [DW-1:0]              Qb_fwd,
    output logic                       Hit_a,
    output logic                       Hit_b
`endif
);

    wb_entry_t              push_entry;
    wb_entry_t              head;
    wb_entry_t [DEPTH-1:0]  ents;
    logic                   a_req;
    logic                   m_push;
    logic                   f_pop;
    logic                   f_full;
    logic                   f_empty;
    logic [(1<<AW)-1:0]     pend_c;

    // Writes to r0 are architecturally dropped on both request paths.
    assign a_req   = A_Valid && (A_Wr != AW'(REG_ZERO));
    assign M_Ready = !Clr && !f_full;
    assign m_push  = M_Valid && M_Ready && (M_Wr != AW'(REG_ZERO));
    assign f_pop   = !a_req && !f_empty;

    assign push_entry = '{valid: 1'b1, wr: REG_AW'(M_Wr), d: REG_DW'(M_D)};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (Clk),
        .clr        (Clr),
        .push       (m_push),
        .push_entry (push_entry),
        .pop        (f_pop),
        .squash     (a_req),
        .squash_wr  (REG_AW'(A_Wr)),
        .head       (head),
        .ents       (ents),
        .cnt        (Cnt),
        .full       (f_full),
        .empty      (f_empty)
    );

    // Write-port register: ALU first, then FIFO head (squashed heads issue as We=0).
    always_ff @(posedge Clk) begin
        if (Clr) begin
            We <= 1'b0;
            Wr <= '0;
            D  <= '0;
        end else if (a_req) begin
            We <= 1'b1;
            Wr <= A_Wr;
            D  <= A_D;
        end else if (!f_empty) begin
            We <= head.valid;
            Wr <= AW'(head.wr);
            D  <= DW'(head.d);
        end else begin
            We <= 1'b0;
        end
    end

    always_comb begin
        pend_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ents[i].valid) begin
                pend_c[ents[i].wr] = 1'b1;
            end
        end
        pend_c[0] = 1'b0;
    end

    assign Pend = pend_c;

`ifdef WB_BYPASS_EN
    assign Hit_a  = We && (Wr == Ra) && (Ra != AW'(REG_ZERO));
    assign Hit_b  = We && (Wr == Rb) && (Rb != AW'(REG_ZERO));
    assign Qa_fwd = Hit_a ? D : '0;
    assign Qb_fwd = Hit_b ? D : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl; covers the WB_BYPASS_EN ports
// when that macro is defined.
module tb_regfile_wb_ctrl;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        A_Valid;
    logic [4:0]  A_Wr;
    logic [31:0] A_D;
    logic        M_Valid;
    logic        M_Ready;
    logic [4:0]  M_Wr;
    logic [31:0] M_D;
    logic [4:0]  Wr;
    logic [31:0] D;
    logic        We;
    logic [31:0] Pend;
    logic [2:0]  Cnt;
`ifdef WB_BYPASS_EN
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic [31:0] Qa_fwd;
    logic [31:0] Qb_fwd;
    logic        Hit_a;
    logic        Hit_b;
`endif

    int checks = 0;
    int errors = 0;

    regfile_wb_ctrl dut (
        .Clk     (Clk),
        .Clr     (Clr),
        .A_Valid (A_Valid),
        .A_Wr    (A_Wr),
        .A_D     (A_D),
        .M_Valid (M_Valid),
        .M_Ready (M_Ready),
        .M_Wr    (M_Wr),
        .M_D     (M_D),
        .Wr      (Wr),
        .D       (D),
        .We      (We),
        .Pend    (Pend),
        .Cnt     (Cnt)
`ifdef WB_BYPASS_EN
        ,
        .Ra      (Ra),
        .Rb      (Rb),
        .Qa_fwd  (Qa_fwd),
        .Qb_fwd  (Qb_fwd),
        .Hit_a   (Hit_a),
        .Hit_b   (Hit_b)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are checked there too.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic a_set(input logic v, input logic [4:0] r, input logic [31:0] d);
        A_Valid = v; A_Wr = r; A_D = d;
    endtask

    task automatic m_set(input logic v, input logic [4:0] r, input logic [31:0] d);
        M_Valid = v; M_Wr = r; M_D = d;
    endtask

    initial begin
        Clr = 1'b1;
        a_set(1'b0, 5'd0, 32'h0);
        m_set(1'b0, 5'd0, 32'h0);
`ifdef WB_BYPASS_EN
        Ra = 5'd0; Rb = 5'd0;
`endif

        // Reset held two cycles
        tick(); tick();
        chk("rst_we", 64'(We), 64'd0);
        chk("rst_wr", 64'(Wr), 64'd0);
        chk("rst_d", 64'(D), 64'd0);
        chk("rst_pend", 64'(Pend), 64'd0);
        chk("rst_mready", 64'(M_Ready), 64'd0);
        Clr = 1'b0;
        tick();
        chk("rel_mready", 64'(M_Ready), 64'd1);
        chk("rel_cnt", 64'(Cnt), 64'd0);

        // ALU only
        a_set(1'b1, 5'd3, 32'hDEADBEEF);
        tick();
        chk("alu_we", 64'(We), 64'd1);
        chk("alu_wr", 64'(Wr), 64'd3);
        chk("alu_d", 64'(D), 64'hDEADBEEF);
        a_set(1'b0, 5'd0, 32'h0);
        tick();
        chk("alu_we_off", 64'(We), 64'd0);
        chk("alu_wr_hold", 64'(Wr), 64'd3);

        // Back-pressure: ALU busy on regs 20..25 while M fills FIFO with regs 5..8
        for (int i = 0; i < 6; i++) begin
            a_set(1'b1, 5'(20 + i), 32'(32'h1000 + i));
            if (i < 4) m_set(1'b1, 5'(5 + i), 32'(101 + i));
            else       m_set(1'b1, 5'd13, 32'hBAD);
            tick();
            chk("bp_alu_we", 64'(We), 64'd1);
            chk("bp_alu_wr", 64'(Wr), 64'(20 + i));
            if (i == 3) begin
                chk("bp_full_cnt", 64'(Cnt), 64'd4);
                chk("bp_full_mready", 64'(M_Ready), 64'd0);
                chk("bp_full_pend", 64'(Pend), 64'h1E0);
            end
        end
        chk("bp_nopush_cnt", 64'(Cnt), 64'd4);
        a_set(1'b0, 5'd0, 32'h0);
        m_set(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_drain_we", 64'(We), 64'd1);
            chk("bp_drain_wr", 64'(Wr), 64'(5 + i));
            chk("bp_drain_d", 64'(D), 64'(101 + i));
            chk("bp_drain_cnt", 64'(Cnt), 64'(3 - i));
        end
        tick();
        chk("bp_idle_we", 64'(We), 64'd0);
        chk("bp_idle_pend", 64'(Pend), 64'd0);

        // Squash: queued M to reg 9 overtaken by ALU to reg 9
        m_set(1'b1, 5'd9, 32'h11);
        tick();
        chk("sq_cnt1", 64'(Cnt), 64'd1);
        chk("sq_pend", 64'(Pend), 64'h200);
        m_set(1'b0, 5'd0, 32'h0);
        a_set(1'b1, 5'd9, 32'h22);
        tick();
        chk("sq_alu_we", 64'(We), 64'd1);
        chk("sq_alu_wr", 64'(Wr), 64'd9);
        chk("sq_alu_d", 64'(D), 64'h22);
        chk("sq_pend_clr", 64'(Pend), 64'd0);
        chk("sq_cnt_keep", 64'(Cnt), 64'd1);
        a_set(1'b0, 5'd0, 32'h0);
        tick();
        chk("sq_pop_we", 64'(We), 64'd0);
        chk("sq_pop_cnt", 64'(Cnt), 64'd0);

        // Squash of an entry pushed in the same cycle as the ALU write
        m_set(1'b1, 5'd9, 32'h33);
        a_set(1'b1, 5'd9, 32'h44);
        tick();
        chk("sqs_we", 64'(We), 64'd1);
        chk("sqs_d", 64'(D), 64'h44);
        chk("sqs_cnt", 64'(Cnt), 64'd1);
        chk("sqs_pend", 64'(Pend), 64'd0);
        m_set(1'b0, 5'd0, 32'h0);
        a_set(1'b0, 5'd0, 32'h0);
        tick();
        chk("sqs_pop_we", 64'(We), 64'd0);
        chk("sqs_pop_cnt", 64'(Cnt), 64'd0);

        // r0: ALU to r0 lets FIFO drain; M to r0 handshakes but is dropped
        m_set(1'b1, 5'd12, 32'h55);
        tick();
        chk("r0_cnt1", 64'(Cnt), 64'd1);
        m_set(1'b0, 5'd0, 32'h0);
        a_set(1'b1, 5'd0, 32'h99);
        tick();
        chk("r0_a_we", 64'(We), 64'd1);
        chk("r0_a_wr", 64'(Wr), 64'd12);
        chk("r0_a_d", 64'(D), 64'h55);
        chk("r0_a_cnt", 64'(Cnt), 64'd0);
        a_set(1'b0, 5'd0, 32'h0);
        m_set(1'b1, 5'd0, 32'h77);
        #1;
        chk("r0_m_ready", 64'(M_Ready), 64'd1);
        tick();
        chk("r0_m_cnt", 64'(Cnt), 64'd0);
        chk("r0_m_pend", 64'(Pend), 64'd0);
        chk("r0_m_we", 64'(We), 64'd0);
        m_set(1'b0, 5'd0, 32'h0);
        tick();
        chk("r0_m_we2", 64'(We), 64'd0);

        // Reset mid-operation with three queued entries
        a_set(1'b1, 5'd30, 32'hA0);
        for (int i = 0; i < 3; i++) begin
            m_set(1'b1, 5'(1 + i), 32'(32'h200 + i));
            tick();
        end
        chk("mr_cnt3", 64'(Cnt), 64'd3);
        chk("mr_pend", 64'(Pend), 64'hE);
        a_set(1'b0, 5'd0, 32'h0);
        m_set(1'b0, 5'd0, 32'h0);
        Clr = 1'b1;
        #1;
        chk("mr_clr_mready", 64'(M_Ready), 64'd0);
        tick();
        Clr = 1'b0;
        chk("mr_cnt0", 64'(Cnt), 64'd0);
        chk("mr_pend0", 64'(Pend), 64'd0);
        chk("mr_we0", 64'(We), 64'd0);
        chk("mr_d0", 64'(D), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mr_no_we", 64'(We), 64'd0);
        end
        chk("mr_end_cnt", 64'(Cnt), 64'd0);

`ifdef WB_BYPASS_EN
        // Forwarding of the value on the write port this cycle
        a_set(1'b1, 5'd3, 32'h55);
        tick();
        a_set(1'b0, 5'd0, 32'h0);
        Ra = 5'd3; Rb = 5'd0;
        #1;
        chk("byp_hit_a", 64'(Hit_a), 64'd1);
        chk("byp_q_a", 64'(Qa_fwd), 64'h55);
        chk("byp_hit_b", 64'(Hit_b), 64'd0);
        chk("byp_q_b", 64'(Qb_fwd), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
